// File: rtl/nbit_grant_decoder.sv
// Purpose: turn a binary winner index into a registered one-hot grant, held until owner release or hold timeout.
// Latency: grant appears the cycle after the index is accepted; every grant is followed by one dead DRAIN cycle.
// Backpressure: index_ready is low while a grant is held and during DRAIN; index_valid/index_in are ignored then.
module nbit_grant_decoder #(
    parameter int  W_DATA   = 32,
    parameter int  MAX_HOLD = 16,
    localparam int W_IDX    = $clog2(W_DATA),
    localparam int W_HOLD   = $clog2(MAX_HOLD + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_IDX-1:0]  index_in,
    input  logic              index_valid,
    output logic              index_ready,
    output logic [W_DATA-1:0] grant_onehot,
    output logic              grant_valid,
    input  logic [W_DATA-1:0] release_in,
    output logic [W_HOLD-1:0] hold_count,
    output logic              timeout,
    output logic              index_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Last hold_count value a grant may show before it is revoked.
    localparam logic [W_HOLD-1:0] HOLD_LAST = W_HOLD'(MAX_HOLD - 1);
    localparam logic [W_DATA-1:0] ONE_HOT0  = W_DATA'(1);

    state_t              state_q;
    logic [W_DATA-1:0]   grant_q;
    logic                grant_valid_q;
    logic [W_HOLD-1:0]   hold_q;
    logic                timeout_q;
    logic                index_error_q;

    logic                idx_in_range_d;
    logic [W_DATA-1:0]   grant_dec_d;
    logic                owner_release_d;

    // W_DATA need not be a power of two, so the top index codes can be illegal.
    assign idx_in_range_d  = (int'(index_in) < W_DATA);
    assign grant_dec_d     = ONE_HOT0 << index_in;
    // The grant vector itself masks release_in down to the owner's bit.
    assign owner_release_d = |(release_in & grant_q);

    // Grant FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            hold_q        <= '0;
            timeout_q     <= 1'b0;
            index_error_q <= 1'b0;
        end else begin
            timeout_q     <= 1'b0;
            index_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (index_valid) begin
                        if (idx_in_range_d) begin
                            state_q       <= GRANT;
                            grant_q       <= grant_dec_d;
                            grant_valid_q <= 1'b1;
                            hold_q        <= '0;
                        end else begin
                            index_error_q <= 1'b1;
                        end
                    end
                end
                GRANT: begin
                    // Release wins over a coinciding timeout, so no pulse in that case.
                    if (owner_release_d || (hold_q == HOLD_LAST)) begin
                        state_q       <= DRAIN;
                        grant_q       <= '0;
                        grant_valid_q <= 1'b0;
                        hold_q        <= '0;
                        timeout_q     <= !owner_release_d;
                    end else begin
                        hold_q <= hold_q + W_HOLD'(1);
                    end
                end
                DRAIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q       <= IDLE;
                    grant_q       <= '0;
                    grant_valid_q <= 1'b0;
                    hold_q        <= '0;
                end
            endcase
        end
    end

    assign index_ready  = (state_q == IDLE);
    assign grant_onehot = grant_q;
    assign grant_valid  = grant_valid_q;
    assign hold_count   = hold_q;
    assign timeout      = timeout_q;
    assign index_error  = index_error_q;

endmodule

// File: tb/tb_nbit_grant_decoder.sv
// Purpose: randomized scoreboard bench for nbit_grant_decoder (6 requesters, hold limit 4).
// Latency: expected grant/error transactions are queued at issue and retired by a negedge monitor.
// Backpressure: the driver only presents indices when the reference timing says the block is idle.
module tb_nbit_grant_decoder;

    localparam int W_DATA   = 6;
    localparam int MAX_HOLD = 4;
    localparam int W_IDX    = $clog2(W_DATA);
    localparam int W_HOLD   = $clog2(MAX_HOLD + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [W_IDX-1:0]  index_in = '0;
    logic              index_valid = 1'b0;
    logic [W_DATA-1:0] release_in = '0;
    logic              index_ready;
    logic [W_DATA-1:0] grant_onehot;
    logic              grant_valid;
    logic [W_HOLD-1:0] hold_count;
    logic              timeout;
    logic              index_error;

    nbit_grant_decoder #(.W_DATA(W_DATA), .MAX_HOLD(MAX_HOLD)) dut (
        .clk          (clk),
        .rst          (rst),
        .index_in     (index_in),
        .index_valid  (index_valid),
        .index_ready  (index_ready),
        .grant_onehot (grant_onehot),
        .grant_valid  (grant_valid),
        .release_in   (release_in),
        .hold_count   (hold_count),
        .timeout      (timeout),
        .index_error  (index_error)
    );

    always #5 clk = ~clk;

    // One expected transaction: either an index_error pulse or a whole grant.
    typedef struct {
        bit is_err;
        int owner;
        int dur;
        bit tmo;
        bit aborted;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    exp_t cur;
    bit   in_grant = 1'b0;
    int   cnt      = 0;
    bit   last_rst = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W_DATA-1:0] noise(input int owner);
        return W_DATA'($urandom) & ~(W_DATA'(1) << owner);
    endfunction

    // Reference rule: release on grant cycle k ends the grant after k cycles,
    // the hold limit caps it at MAX_HOLD, and only k > MAX_HOLD is a timeout.
    task automatic do_grant(input int owner, input int k);
        exp_t e;
        int   dur;
        dur       = (k < MAX_HOLD) ? k : MAX_HOLD;
        e.is_err  = 1'b0;
        e.owner   = owner;
        e.dur     = dur;
        e.tmo     = (k > MAX_HOLD);
        e.aborted = 1'b0;
        step();
        rst = 1'b0; index_valid = 1'b1; index_in = W_IDX'(owner); release_in = W_DATA'($urandom);
        sb.push_back(e);
        for (int c = 1; c <= dur; c++) begin
            step();
            release_in  = noise(owner) | ((c == k) ? (W_DATA'(1) << owner) : '0);
            index_valid = 1'($urandom);
            index_in    = W_IDX'($urandom);
        end
        step();
        release_in  = W_DATA'($urandom);
        index_valid = 1'($urandom);
        index_in    = W_IDX'($urandom);
    endtask

    task automatic do_err(input int idx);
        exp_t e;
        e.is_err = 1'b1; e.owner = idx; e.dur = 0; e.tmo = 1'b0; e.aborted = 1'b0;
        step();
        rst = 1'b0; index_valid = 1'b1; index_in = W_IDX'(idx); release_in = W_DATA'($urandom);
        sb.push_back(e);
    endtask

    task automatic do_idle();
        step();
        index_valid = 1'b0; index_in = W_IDX'($urandom); release_in = W_DATA'($urandom);
    endtask

    // Grant 'owner', hit reset on its third cycle, keep next_idx valid through reset.
    task automatic do_reset_mid(input int owner, input int next_idx);
        exp_t e;
        e.is_err = 1'b0; e.owner = owner; e.dur = 3; e.tmo = 1'b0; e.aborted = 1'b1;
        step();
        index_valid = 1'b1; index_in = W_IDX'(owner); release_in = noise(owner);
        sb.push_back(e);
        step(); release_in = noise(owner);
        step(); release_in = noise(owner);
        step();
        rst = 1'b1; index_valid = 1'b1; index_in = W_IDX'(next_idx); release_in = noise(owner);
    endtask

    // Monitor: retires scoreboard entries as grants and error pulses appear.
    initial begin
        forever begin
            @(negedge clk);
            chk("gv_vs_onehot", 32'(grant_valid), 32'(grant_onehot != '0));
            chk("onehot0", 32'($onehot0(grant_onehot)), 32'd1);
            if (last_rst) begin
                chk("rst_grant", 32'(grant_onehot), 32'd0);
                chk("rst_hold", 32'(hold_count), 32'd0);
                chk("rst_timeout", 32'(timeout), 32'd0);
                chk("rst_err", 32'(index_error), 32'd0);
                chk("rst_ready", 32'(index_ready), 32'd1);
                if (in_grant) begin
                    chk("abort_expected", 32'(cur.aborted), 32'd1);
                    chk("abort_len", 32'(cnt), 32'(cur.dur));
                    in_grant = 1'b0;
                end
            end else if (in_grant && grant_valid) begin
                chk("grant_stable", 32'(grant_onehot), 32'd1 << cur.owner);
                chk("hold_count", 32'(hold_count), 32'(cnt));
                chk("grant_ready", 32'(index_ready), 32'd0);
                chk("grant_timeout", 32'(timeout), 32'd0);
                chk("grant_err", 32'(index_error), 32'd0);
                cnt++;
            end else if (in_grant) begin
                chk("grant_len", 32'(cnt), 32'(cur.dur));
                chk("drain_timeout", 32'(timeout), 32'(cur.tmo));
                chk("drain_ready", 32'(index_ready), 32'd0);
                chk("drain_hold", 32'(hold_count), 32'd0);
                chk("drain_err", 32'(index_error), 32'd0);
                chk("drain_not_abort", 32'(cur.aborted), 32'd0);
                in_grant = 1'b0;
            end else if (grant_valid) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL sb_underflow: unexpected grant 0x%0h at %0t", grant_onehot, $time);
                end else begin
                    cur = sb.pop_front();
                    chk("grant_kind", 32'(cur.is_err), 32'd0);
                    chk("grant_onehot", 32'(grant_onehot), 32'd1 << cur.owner);
                    chk("grant_hold0", 32'(hold_count), 32'd0);
                    chk("grant_ready", 32'(index_ready), 32'd0);
                    chk("grant_timeout", 32'(timeout), 32'd0);
                    chk("grant_err", 32'(index_error), 32'd0);
                    cnt      = 1;
                    in_grant = 1'b1;
                end
            end else begin
                chk("idle_ready", 32'(index_ready), 32'd1);
                chk("idle_timeout", 32'(timeout), 32'd0);
                chk("idle_hold", 32'(hold_count), 32'd0);
                if (index_error) begin
                    if (sb.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL sb_underflow: unexpected index_error at %0t", $time);
                    end else begin
                        cur = sb.pop_front();
                        chk("err_kind", 32'(cur.is_err), 32'd1);
                    end
                end
            end
            last_rst = rst;
        end
    end

    // Driver: directed corner cases first, then random traffic.
    initial begin
        repeat (2) step();
        rst = 1'b0;
        do_grant(5, 2);
        do_grant(3, 3);
        do_grant(2, 6);
        do_grant(1, MAX_HOLD);
        do_grant(0, 1);
        do_err(6);
        do_err(7);
        do_grant(5, 5);
        do_idle();
        do_reset_mid(2, 4);
        do_grant(4, 2);
        for (int i = 0; i < 80; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6)
                do_grant(int'($urandom_range(0, W_DATA - 1)), int'($urandom_range(1, MAX_HOLD + 2)));
            else if (r < 8)
                do_err(int'($urandom_range(W_DATA, (1 << W_IDX) - 1)));
            else
                do_idle();
        end
        repeat (4) do_idle();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("no_open_grant", 32'(in_grant), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
